simple_uart: RTL and testbench
==============================

Name: simple_uart

Overview:
- Memory-mapped 8N1 UART with a programmable baud divider, a one-byte transmit shift path and a one-byte receive buffer.
- Sits on the SoC data bus behind the UART address decode.
- Software writes the data register to transmit and reads it to receive.
- The bus master stalls a transmit write while a frame is in progress.

Parameters:
- DEFAULT_DIV, 217, reset value of the divider register (clock cycles per bit; 25 MHz / 115200).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ser_tx  out  1  serial transmit line, idle high.
- ser_rx  in  1  serial receive line; already synchronised externally.
- reg_div_we  in  4  byte write enables for the divider register.
- reg_div_di  in  32  divider write data.
- reg_div_do  out  32  current divider value.
- reg_dat_we  in  1  data register write strobe (start transmit).
- reg_dat_re  in  1  data register read strobe (consume received byte).
- reg_dat_di  in  32  transmit data; only bits [7:0] are used.
- reg_dat_do  out  32  received byte, or all-ones if none is available.
- reg_dat_wait  out  1  combinational stall for a write that cannot be accepted.

Behaviour:
- Reset state:
  - cfg_div = DEFAULT_DIV; ser_tx = 1; TX idle; RX idle; rx_valid = 0.
  - A 15-bit all-ones "dummy" idle frame is armed so the line stays high for 15 bit times after reset.
- Divider register:
  - Each byte lane i with reg_div_we[i] = 1 loads reg_div_di[8i+7:8i].
  - reg_div_do = cfg_div.
  - Effective bit period P = max(cfg_div, 4) cycles.
  - Any divider write re-arms the dummy idle frame, which starts once the current TX frame ends.
- Transmit:
  - A 10-bit shift register drives ser_tx from bit 0; TX is busy while bits remain or a dummy frame is pending.
  - reg_dat_wait = reg_dat_we & busy.
  - A write with reg_dat_we = 1 and wait = 0 loads {1, data[7:0], 0}, i.e. start bit, LSB first, then stop bit.
  - ser_tx shows the start bit from the cycle after acceptance.
  - Each bit is held for exactly P cycles; the shift fills with 1s.
  - Busy clears after the stop bit's P cycles, so a full frame takes 10·P cycles.
  - A pending dummy frame takes priority over a new write; it holds the line high for 15·P cycles.
  - A write arriving in the same cycle that the last bit ends is stalled for that cycle and accepted on the next cycle.
- Receive FSM, states IDLE → START → DATA(8) → STOP:
  - IDLE: on ser_rx = 0, go to START and clear the counter.
  - START: after P/2 cycles (integer divide), sample ser_rx.
    - If 0, go to DATA with the counter cleared.
    - If 1 (glitch), return to IDLE.
  - DATA: every P cycles, sample ser_rx into the LSB-first shift. After 8 samples go to STOP.
  - STOP: after P cycles, sample ser_rx.
    - If 1: rx_data ← shift and rx_valid ← 1.
    - If 0 (framing error): discard the byte; rx_valid is unchanged.
    - Either way return to IDLE.
  - A new byte overwrites an unread byte (no overrun flag).
- Read data and consume:
  - reg_dat_do = rx_valid ? {24'h0, rx_data} : 32'hFFFF_FFFF.
  - reg_dat_re clears rx_valid at the next edge.
  - If reg_dat_re coincides with a new byte landing, the new byte wins and rx_valid = 1.
- RX and TX are fully independent; a divider write during a frame takes effect from the next bit counter compare.
- Reset asserted mid-frame aborts both paths immediately: ser_tx = 1, received data is lost.

Test Plan:
- Reset, DEFAULT_DIV = 8:
  - ser_tx stays 1 for 15·8 = 120 cycles after reset release.
  - reg_div_do = 8; reg_dat_do = 32'hFFFFFFFF.
- Write 0x55 after the dummy frame ends:
  - ser_tx = 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each bit held 8 cycles.
  - reg_dat_wait = 0 on acceptance.
- Second write 0xA3 issued 3 cycles after the first accept:
  - reg_dat_wait = 1 until 80 cycles after the first accept.
  - The write is then accepted and ser_tx frames 0xA3.
- Drive an 8N1 frame of 0x3C on ser_rx at 8 cycles/bit:
  - reg_dat_do = 0x0000003C after the stop bit.
  - Pulse reg_dat_re → reg_dat_do = 32'hFFFFFFFF next cycle.
- Negative tests on ser_rx:
  - A 2-cycle low glitch → no byte received.
  - A frame with stop bit 0 → byte discarded; reg_dat_do remains all-ones.
- Write reg_div_we = 4'b0001 with data 0x10:
  - reg_div_do = 16.
  - A 15·16-cycle idle dummy frame follows, then a write of 0xFF gives 16-cycle bits.
  - Loop ser_tx to ser_rx: reg_dat_do = 0xFF.

Source files
------------

// File: rtl/simple_uart_if.sv
// simple_uart_if
//   Register-bus bundle between the SoC bus master and the UART.
//   Divider register: reg_div_we (byte enables), reg_div_di (write data),
//   reg_div_do (current value).
//   Data register: reg_dat_we (write strobe, starts a transmit),
//   reg_dat_re (read strobe, consumes the received byte),
//   reg_dat_di (transmit byte in [7:0]), reg_dat_do (received byte or all-ones),
//   reg_dat_wait (stall for a write the transmitter cannot take yet).
//   master: the bus side that issues accesses; slave: the UART itself.
interface simple_uart_if;
  logic [3:0]  reg_div_we;
  logic [31:0] reg_div_di;
  logic [31:0] reg_div_do;
  logic        reg_dat_we;
  logic        reg_dat_re;
  logic [31:0] reg_dat_di;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;

  modport master (
    output reg_div_we, reg_div_di, reg_dat_we, reg_dat_re, reg_dat_di,
    input  reg_div_do, reg_dat_do, reg_dat_wait
  );

  modport slave (
    input  reg_div_we, reg_div_di, reg_dat_we, reg_dat_re, reg_dat_di,
    output reg_div_do, reg_dat_do, reg_dat_wait
  );
endinterface

// File: rtl/simple_uart.sv
// simple_uart
//   Memory-mapped 8N1 UART with a programmable baud divider, a one-byte
//   transmit shift path and a one-byte receive buffer.
//   Ports:
//     clk    - system clock, all state changes on the rising edge
//     reset  - asynchronous, active-high reset
//     ser_tx - serial transmit line, idles high
//     ser_rx - serial receive line, already synchronised outside
//     bus    - register bus (divider register and data register)
//   Parameter DEFAULT_DIV is the divider reset value in clock cycles per bit.
module simple_uart #(
  parameter int unsigned DEFAULT_DIV = 217
) (
  input  logic         clk,
  input  logic         reset,
  output logic         ser_tx,
  input  logic         ser_rx,
  simple_uart_if.slave bus
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [31:0] cfg_div;
  logic [31:0] bit_period;
  logic [31:0] half_period;

  logic [9:0]  tx_pattern;
  logic [3:0]  tx_bits;
  logic [31:0] tx_cnt;
  logic        tx_dummy;
  logic        tx_busy;

  rx_state_t   rx_state, rx_state_next;
  logic [31:0] rx_cnt, rx_cnt_next;
  logic [2:0]  rx_bits, rx_bits_next;
  logic [7:0]  rx_shift, rx_shift_next;
  logic [7:0]  rx_data, rx_data_next;
  logic        rx_valid, rx_valid_next;

  // Very small dividers would leave the receiver no room to find the bit
  // centre, so the bit period never drops below four cycles.
  assign bit_period  = (cfg_div < 32'd4) ? 32'd4 : cfg_div;
  assign half_period = bit_period >> 1;

  assign bus.reg_div_do   = cfg_div;
  assign bus.reg_dat_do   = rx_valid ? {24'h0, rx_data} : 32'hFFFF_FFFF;
  assign tx_busy          = (tx_bits != 4'd0) || tx_dummy;
  assign bus.reg_dat_wait = bus.reg_dat_we & tx_busy;
  assign ser_tx           = tx_pattern[0];

  // Divider register with independent byte lanes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_div <= 32'(DEFAULT_DIV);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (bus.reg_div_we[i]) cfg_div[8*i +: 8] <= bus.reg_div_di[8*i +: 8];
      end
    end
  end

  // Transmit path. A pending dummy frame (15 idle-high bits) wins over a new
  // byte so the far end sees a clean idle gap after reset or a baud change.
  // The divider-write re-arm sits last so it survives a dummy load that
  // happens in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_pattern <= '1;
      tx_bits    <= 4'd0;
      tx_cnt     <= 32'd0;
      tx_dummy   <= 1'b1;
    end else begin
      if ((tx_bits == 4'd0) && tx_dummy) begin
        tx_pattern <= '1;
        tx_bits    <= 4'd15;
        tx_cnt     <= 32'd0;
        tx_dummy   <= 1'b0;
      end else if (bus.reg_dat_we && !tx_busy) begin
        tx_pattern <= {1'b1, bus.reg_dat_di[7:0], 1'b0};
        tx_bits    <= 4'd10;
        tx_cnt     <= 32'd0;
      end else if (tx_bits != 4'd0) begin
        // >= rather than == so shrinking the divider mid-bit cannot strand the counter.
        if (tx_cnt >= bit_period - 32'd1) begin
          tx_pattern <= {1'b1, tx_pattern[9:1]};
          tx_bits    <= tx_bits - 4'd1;
          tx_cnt     <= 32'd0;
        end else begin
          tx_cnt <= tx_cnt + 32'd1;
        end
      end
      if (bus.reg_div_we != 4'h0) tx_dummy <= 1'b1;
    end
  end

  // Receive state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= 32'd0;
      rx_bits  <= 3'd0;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      rx_state <= rx_state_next;
      rx_cnt   <= rx_cnt_next;
      rx_bits  <= rx_bits_next;
      rx_shift <= rx_shift_next;
      rx_data  <= rx_data_next;
      rx_valid <= rx_valid_next;
    end
  end

  // Receive next-state logic. The start bit is confirmed half a period after
  // the falling edge; every later sample is a whole period apart, which lands
  // each one near the centre of its bit. A byte that completes in the same
  // cycle as a read strobe must stay valid, so the landing update comes after
  // the read clear.
  always_comb begin
    rx_state_next = rx_state;
    rx_cnt_next   = rx_cnt + 32'd1;
    rx_bits_next  = rx_bits;
    rx_shift_next = rx_shift;
    rx_data_next  = rx_data;
    rx_valid_next = rx_valid;
    if (bus.reg_dat_re) rx_valid_next = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_next = 32'd0;
        if (!ser_rx) rx_state_next = RX_START;
      end
      RX_START: begin
        if (rx_cnt >= half_period - 32'd1) begin
          rx_cnt_next   = 32'd0;
          rx_bits_next  = 3'd0;
          rx_state_next = ser_rx ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt >= bit_period - 32'd1) begin
          rx_cnt_next   = 32'd0;
          rx_shift_next = {ser_rx, rx_shift[7:1]};
          rx_bits_next  = rx_bits + 3'd1;
          if (rx_bits == 3'd7) rx_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt >= bit_period - 32'd1) begin
          rx_cnt_next   = 32'd0;
          rx_state_next = RX_IDLE;
          if (ser_rx) begin
            rx_data_next  = rx_shift;
            rx_valid_next = 1'b1;
          end
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_simple_uart.sv
// tb_simple_uart
//   Self-checking bench for simple_uart built with DEFAULT_DIV = 8.
//   A negedge monitor keeps a reference model of the transmit line as a
//   queue of expected per-cycle line levels and checks ser_tx, reg_dat_wait
//   and reg_div_do every cycle. Receive behaviour is checked with a
//   table of frames, hand-written corner sequences and random frames
//   against a valid/data model of the receive buffer.
module tb_simple_uart;

  localparam int DIV0 = 8;

  typedef struct {
    logic [7:0]  data;
    logic        stop_bit;
    logic        do_read;
    logic [31:0] exp_do;
    logic [31:0] exp_after;
  } rx_vec_t;

  logic clk       = 1'b0;
  logic reset     = 1'b1;
  logic ser_tx;
  logic bench_rx  = 1'b1;
  logic loopback  = 1'b0;
  logic dut_rx;

  int cycle      = 0;
  int compared   = 0;
  int mismatched = 0;

  // Reference model state.
  bit          tx_q[$];
  bit          dummy_pending = 1'b1;
  logic [31:0] model_div = 32'(DIV0);
  bit          model_rx_valid = 1'b0;
  logic [7:0]  model_rx_data = 8'h00;

  int          mon_pre;
  bit          mon_busy;
  int          mon_p;
  logic [9:0]  mon_frame;

  rx_vec_t rx_vec [7];

  simple_uart_if uart_bus ();

  simple_uart #(.DEFAULT_DIV(DIV0)) dut (
    .clk    (clk),
    .reset  (reset),
    .ser_tx (ser_tx),
    .ser_rx (dut_rx),
    .bus    (uart_bus.slave)
  );

  assign dut_rx = loopback ? ser_tx : bench_rx;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, got, exp);
    end
  endtask

  function automatic int period_of(input logic [31:0] d);
    return (d < 32'd4) ? 4 : int'(d);
  endfunction

  function automatic logic [31:0] model_dat_do();
    return model_rx_valid ? {24'h0, model_rx_data} : 32'hFFFF_FFFF;
  endfunction

  // Transmit-line model: each accepted byte or dummy frame becomes a run of
  // expected line levels, one entry per clock cycle.
  always @(negedge clk) begin
    if (reset) begin
      tx_q.delete();
      dummy_pending = 1'b1;
      model_div     = 32'(DIV0);
      checkOutput("reset_ser_tx", {31'h0, ser_tx}, 32'h1);
      checkOutput("reset_div_do", uart_bus.reg_div_do, 32'(DIV0));
    end else begin
      mon_pre  = tx_q.size();
      mon_busy = (mon_pre > 0) || dummy_pending;
      checkOutput("tx_line", {31'h0, ser_tx}, (mon_pre > 0) ? {31'h0, tx_q[0]} : 32'h1);
      checkOutput("tx_wait", {31'h0, uart_bus.reg_dat_wait}, {31'h0, uart_bus.reg_dat_we & mon_busy});
      checkOutput("div_do", uart_bus.reg_div_do, model_div);
      if (mon_pre > 0) void'(tx_q.pop_front());
      for (int i = 0; i < 4; i++) begin
        if (uart_bus.reg_div_we[i]) model_div[8*i +: 8] = uart_bus.reg_div_di[8*i +: 8];
      end
      mon_p = period_of(model_div);
      if (mon_pre == 0 && dummy_pending) begin
        repeat (15 * mon_p) tx_q.push_back(1'b1);
        dummy_pending = 1'b0;
      end else if (mon_pre == 0 && uart_bus.reg_dat_we === 1'b1) begin
        mon_frame = {1'b1, uart_bus.reg_dat_di[7:0], 1'b0};
        for (int b = 0; b < 10; b++) repeat (mon_p) tx_q.push_back(mon_frame[b]);
      end
      if (uart_bus.reg_div_we != 4'h0) dummy_pending = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Holds the write strobe until the UART stops stalling it.
  task automatic writeData(input logic [7:0] d, output int accept_cycle, output int wait_cycles);
    logic [31:0] r;
    r = $urandom;
    wait_cycles  = 0;
    accept_cycle = -1;
    uart_bus.reg_dat_di = {r[31:8], d};
    uart_bus.reg_dat_we = 1'b1;
    forever begin
      #1;
      if (!uart_bus.reg_dat_wait) begin
        accept_cycle = cycle;
        break;
      end
      wait_cycles++;
      if (wait_cycles > 4000) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL write_timeout at cycle %0d: got stall of %0d cycles, expected acceptance", cycle, wait_cycles);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    uart_bus.reg_dat_we = 1'b0;
  endtask

  task automatic sendRx(input logic [7:0] d, input logic stop_bit, input int p);
    bench_rx = 1'b0;
    ticks(p);
    for (int k = 0; k < 8; k++) begin
      bench_rx = d[k];
      ticks(p);
    end
    bench_rx = stop_bit;
    ticks(p);
    bench_rx = 1'b1;
    ticks(2 * p);
    if (stop_bit) begin
      model_rx_valid = 1'b1;
      model_rx_data  = d;
    end
  endtask

  task automatic readPulse();
    uart_bus.reg_dat_re = 1'b1;
    tick();
    uart_bus.reg_dat_re = 1'b0;
    model_rx_valid = 1'b0;
  endtask

  task automatic applyStimulus(input rx_vec_t v, input int idx);
    sendRx(v.data, v.stop_bit, DIV0);
    checkOutput($sformatf("rx_vec%0d_do", idx), uart_bus.reg_dat_do, v.exp_do);
    checkOutput($sformatf("rx_vec%0d_model", idx), uart_bus.reg_dat_do, model_dat_do());
    if (v.do_read) readPulse();
    checkOutput($sformatf("rx_vec%0d_after", idx), uart_bus.reg_dat_do, v.exp_after);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog at cycle %0d: got no finish, expected end of test", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0, c1, w0, w1, acc, w;
    int high_cycles;
    logic [9:0] exp_frame;

    rx_vec[0] = '{8'h3C, 1'b1, 1'b1, 32'h0000_003C, 32'hFFFF_FFFF};
    rx_vec[1] = '{8'h5A, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    rx_vec[2] = '{8'h81, 1'b1, 1'b0, 32'h0000_0081, 32'h0000_0081};
    rx_vec[3] = '{8'h7E, 1'b1, 1'b1, 32'h0000_007E, 32'hFFFF_FFFF};
    rx_vec[4] = '{8'h00, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    rx_vec[5] = '{8'h00, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000};
    rx_vec[6] = '{8'hC5, 1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF};

    uart_bus.reg_div_we = 4'h0;
    uart_bus.reg_div_di = 32'h0;
    uart_bus.reg_dat_we = 1'b0;
    uart_bus.reg_dat_re = 1'b0;
    uart_bus.reg_dat_di = 32'h0;

    // Reset and the idle dummy frame.
    ticks(3);
    reset = 1'b0;
    checkOutput("post_reset_div_do", uart_bus.reg_div_do, 32'd8);
    checkOutput("post_reset_dat_do", uart_bus.reg_dat_do, 32'hFFFF_FFFF);
    high_cycles = 0;
    repeat (15 * DIV0) begin
      tick();
      if (ser_tx === 1'b1) high_cycles++;
    end
    checkOutput("dummy_high_cycles", 32'(high_cycles), 32'd120);
    ticks(5);

    // First write is taken at once, the second stalls until the frame ends.
    writeData(8'h55, c0, w0);
    checkOutput("w55_wait_cycles", 32'(w0), 32'd0);
    ticks(2);
    writeData(8'hA3, c1, w1);
    checkOutput("a3_wait_cycles", 32'(w1), 32'd78);
    checkOutput("a3_accept_offset", 32'(c1 - c0), 32'd81);
    exp_frame = {1'b1, 8'hA3, 1'b0};
    ticks(4);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("a3_bit%0d", k), {31'h0, ser_tx}, {31'h0, exp_frame[k]});
      ticks(8);
    end
    ticks(10);

    // Table of receive frames.
    for (int i = 0; i < 7; i++) applyStimulus(rx_vec[i], i);

    // Short low glitch must not produce a byte, and the receiver must recover.
    bench_rx = 1'b0;
    ticks(2);
    bench_rx = 1'b1;
    ticks(20);
    checkOutput("glitch_no_byte", uart_bus.reg_dat_do, 32'hFFFF_FFFF);
    sendRx(8'h11, 1'b1, DIV0);
    checkOutput("after_glitch", uart_bus.reg_dat_do, 32'h0000_0011);

    // Read strobe in the very cycle a new byte lands: the new byte survives.
    fork
      sendRx(8'h96, 1'b1, DIV0);
      begin
        ticks(76);
        uart_bus.reg_dat_re = 1'b1;
        tick();
        uart_bus.reg_dat_re = 1'b0;
      end
    join
    checkOutput("read_vs_land", uart_bus.reg_dat_do, 32'h0000_0096);
    readPulse();
    checkOutput("read_clears", uart_bus.reg_dat_do, 32'hFFFF_FFFF);

    // Random traffic on both paths at once.
    fork
      begin
        for (int n = 0; n < 6; n++) begin
          ticks($urandom_range(0, 20));
          writeData(8'($urandom), acc, w);
        end
      end
      begin
        for (int n = 0; n < 6; n++) begin
          logic [7:0] d;
          logic       s;
          ticks($urandom_range(0, 10));
          d = 8'($urandom);
          s = ($urandom_range(0, 3) != 0);
          sendRx(d, s, DIV0);
          checkOutput("rand_rx_do", uart_bus.reg_dat_do, model_dat_do());
          if ($urandom_range(0, 1) == 1) begin
            readPulse();
            checkOutput("rand_rx_read", uart_bus.reg_dat_do, model_dat_do());
          end
        end
      end
    join
    ticks(100);

    // Reset in the middle of a transmit frame with a byte waiting.
    sendRx(8'h42, 1'b1, DIV0);
    checkOutput("pre_reset_byte", uart_bus.reg_dat_do, 32'h0000_0042);
    writeData(8'h00, acc, w);
    ticks(20);
    reset = 1'b1;
    tick();
    checkOutput("reset_tx_abort", {31'h0, ser_tx}, 32'h1);
    checkOutput("reset_rx_lost", uart_bus.reg_dat_do, 32'hFFFF_FFFF);
    ticks(2);
    reset = 1'b0;
    model_rx_valid = 1'b0;
    ticks(15 * DIV0 + 10);

    // Divider write on byte lane 0 only, then a loopback frame at 16 cycles/bit.
    uart_bus.reg_div_di = 32'hABCD_EF10;
    uart_bus.reg_div_we = 4'b0001;
    tick();
    uart_bus.reg_div_we = 4'h0;
    checkOutput("div_do_16", uart_bus.reg_div_do, 32'd16);
    loopback = 1'b1;
    writeData(8'hFF, acc, w);
    checkOutput("dummy16_stall", 32'(w), 32'd241);
    ticks(10 * 16 + 16);
    checkOutput("loopback_ff", uart_bus.reg_dat_do, 32'h0000_00FF);
    ticks(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
